// File: rtl/defs.sv
// Shared definitions for the temperature monitor: command opcodes, response
// codes, alarm and command state encodings, and saturating threshold helpers.
package tmod_pkg;

  // Command opcodes from the bus Master; encodings 6 and 7 are undefined.
  typedef enum logic [2:0] {
    TMOD_NOP      = 3'd0,
    TMOD_SET_HI   = 3'd1,
    TMOD_SET_LO   = 3'd2,
    TMOD_SET_HYST = 3'd3,
    TMOD_READ     = 3'd4,
    TMOD_CLR_AVG  = 3'd5
  } TMOD_OP;

  // Response codes driven on status.
  localparam logic [1:0] TMOD_STATUS_OK   = 2'b00;
  localparam logic [1:0] TMOD_STATUS_HOT  = 2'b01;
  localparam logic [1:0] TMOD_STATUS_COLD = 2'b10;
  localparam logic [1:0] TMOD_STATUS_ERR  = 2'b11;

  // Alarm states share their encoding with the status code reported for them.
  typedef enum logic [1:0] {
    ALARM_NORMAL = 2'b00,
    ALARM_HOT    = 2'b01,
    ALARM_COLD   = 2'b10
  } alarm_e;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'd0,
    CMD_EXEC = 2'd1,
    CMD_RESP = 2'd2
  } cmd_e;

  // hi - hyst, clamped at 0.
  function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] d;
    d = {1'b0, a} - {5'b0, b};
    return d[8] ? 8'd0 : d[7:0];
  endfunction

  // lo + hyst, clamped at 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {5'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/tmod_avg.sv
// Moving-average filter: shifts qualified samples into a history, sums it and
// registers the truncated mean together with a "history full" flag.
module tmod_avg #(
  parameter int AVG_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [7:0] sample,
  input  logic       sample_vld,
  output logic [7:0] avg,
  output logic       avg_ok
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = 8 + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;

  logic [DEPTH-1:0][7:0] hist_q, hist_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [SUM_W-1:0]      sum;
  logic [7:0]            avg_q;
  logic                  avg_ok_q;
  logic                  full;

  assign full = (fill_q == FILL_W'(DEPTH));

  // Clear has priority over a same-cycle sample, so that sample is dropped.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hist
      if (gi == 0) begin : g_head
        assign hist_d[gi] = clear ? 8'd0 : (sample_vld ? sample : hist_q[gi]);
      end else begin : g_tail
        assign hist_d[gi] = clear ? 8'd0 : (sample_vld ? hist_q[gi-1] : hist_q[gi]);
      end
    end
  endgenerate

  // Fill count saturates at the history depth.
  always_comb begin
    fill_d = fill_q;
    if (clear) fill_d = '0;
    else if (sample_vld && !full) fill_d = fill_q + 1'b1;
  end

  // Sum of the whole history; wide enough that it never overflows.
  always_comb begin
    sum = '0;
    for (int i = 0; i < DEPTH; i++) sum = sum + SUM_W'(hist_q[i]);
  end

  // History, fill count, and the registered mean with its qualifier aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q   <= '0;
      fill_q   <= '0;
      avg_q    <= '0;
      avg_ok_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      avg_q    <= clear ? 8'd0 : sum[SUM_W-1:AVG_LOG2];
      avg_ok_q <= clear ? 1'b0 : full;
    end
  end

  assign avg    = avg_q;
  assign avg_ok = avg_ok_q;

endmodule

// File: rtl/tmod_monitor.sv
// Slave-side temperature monitor: averaged alarm FSM with thresholds and
// hysteresis, plus a three-state command engine answering the bus Master.
module tmod_monitor
  import tmod_pkg::*;
#(
  parameter int         AVG_LOG2     = 2,
  parameter logic [7:0] HI_DEFAULT   = 8'd80,
  parameter logic [7:0] LO_DEFAULT   = 8'd10,
  parameter logic [3:0] HYST_DEFAULT = 4'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] op,
  input  logic [7:0] opnd,
  output logic [1:0] status,
  output logic       valid,
  output logic       ready,
  input  logic [7:0] sample,
  input  logic       sample_vld,
  output logic       alarm_hot,
  output logic       alarm_cold
);

  cmd_e       cmd_q, cmd_d;
  alarm_e     alarm_q, alarm_d;
  logic [2:0] op_q;
  logic [7:0] opnd_q;
  logic [7:0] hi_q, hi_d, lo_q, lo_d;
  logic [3:0] hyst_q, hyst_d;
  logic [1:0] status_q, status_d;
  logic       valid_q, ready_q, alarm_hot_q, alarm_cold_q;
  logic       accept, clr_exec, avg_ok;
  logic [7:0] avg, hot_exit, cold_exit;

  assign accept   = (cmd_q == CMD_IDLE) && ready_q && (op != TMOD_NOP);
  assign clr_exec = (cmd_q == CMD_EXEC) && (op_q == TMOD_CLR_AVG);

  tmod_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
    .clk        (clk),
    .reset      (reset),
    .clear      (clr_exec),
    .sample     (sample),
    .sample_vld (sample_vld),
    .avg        (avg),
    .avg_ok     (avg_ok)
  );

  assign hot_exit  = sat_sub8(hi_q, hyst_q);
  assign cold_exit = sat_add8(lo_q, hyst_q);

  // Alarm next state; a clear or an incomplete history pins it to NORMAL.
  always_comb begin
    alarm_d = alarm_q;
    if (clr_exec || !avg_ok) begin
      alarm_d = ALARM_NORMAL;
    end else begin
      case (alarm_q)
        ALARM_NORMAL: if (avg > hi_q) alarm_d = ALARM_HOT;
                      else if (avg < lo_q) alarm_d = ALARM_COLD;
        ALARM_HOT:    if (avg < lo_q) alarm_d = ALARM_COLD;
                      else if (avg <= hot_exit) alarm_d = ALARM_NORMAL;
        ALARM_COLD:   if (avg > hi_q) alarm_d = ALARM_HOT;
                      else if (avg >= cold_exit) alarm_d = ALARM_NORMAL;
        default:      alarm_d = ALARM_NORMAL;
      endcase
    end
  end

  // Command sequencing; EXEC decides the write and the response code. The
  // reported alarm is alarm_d because that is what alarm_q holds during RESP.
  always_comb begin
    cmd_d    = cmd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hyst_d   = hyst_q;
    status_d = status_q;
    case (cmd_q)
      CMD_IDLE: if (accept) cmd_d = CMD_EXEC;
      CMD_EXEC: begin
        cmd_d = CMD_RESP;
        case (op_q)
          TMOD_SET_HI: begin
            if (opnd_q <= lo_q) status_d = TMOD_STATUS_ERR;
            else begin
              hi_d     = opnd_q;
              status_d = alarm_d;
            end
          end
          TMOD_SET_LO: begin
            if (opnd_q >= hi_q) status_d = TMOD_STATUS_ERR;
            else begin
              lo_d     = opnd_q;
              status_d = alarm_d;
            end
          end
          TMOD_SET_HYST: begin
            if (opnd_q > 8'd15) status_d = TMOD_STATUS_ERR;
            else begin
              hyst_d   = opnd_q[3:0];
              status_d = alarm_d;
            end
          end
          TMOD_READ:    status_d = alarm_d;
          TMOD_CLR_AVG: status_d = TMOD_STATUS_OK;
          default:      status_d = TMOD_STATUS_ERR;
        endcase
      end
      default: cmd_d = CMD_IDLE;
    endcase
  end

  // State, configuration and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q        <= CMD_IDLE;
      alarm_q      <= ALARM_NORMAL;
      op_q         <= TMOD_NOP;
      opnd_q       <= '0;
      hi_q         <= HI_DEFAULT;
      lo_q         <= LO_DEFAULT;
      hyst_q       <= HYST_DEFAULT;
      status_q     <= TMOD_STATUS_OK;
      valid_q      <= 1'b0;
      ready_q      <= 1'b0;
      alarm_hot_q  <= 1'b0;
      alarm_cold_q <= 1'b0;
    end else begin
      cmd_q        <= cmd_d;
      alarm_q      <= alarm_d;
      if (accept) begin
        op_q   <= op;
        opnd_q <= opnd;
      end
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      hyst_q       <= hyst_d;
      status_q     <= status_d;
      valid_q      <= (cmd_d == CMD_RESP);
      ready_q      <= (cmd_d == CMD_IDLE);
      alarm_hot_q  <= (alarm_d == ALARM_HOT);
      alarm_cold_q <= (alarm_d == ALARM_COLD);
    end
  end

  assign status     = status_q;
  assign valid      = valid_q;
  assign ready      = ready_q;
  assign alarm_hot  = alarm_hot_q;
  assign alarm_cold = alarm_cold_q;

endmodule

// File: tb/tb_tmod_monitor.sv
// Directed bench for tmod_monitor with hand-computed averages and alarm states.
module tb_tmod_monitor;
  import tmod_pkg::*;

  logic       clk;
  logic       reset;
  logic [2:0] op;
  logic [7:0] opnd;
  logic [1:0] status;
  logic       valid;
  logic       ready;
  logic [7:0] sample;
  logic       sample_vld;
  logic       alarm_hot;
  logic       alarm_cold;

  int checks = 0;
  int errors = 0;

  tmod_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .opnd       (opnd),
    .status     (status),
    .valid      (valid),
    .ready      (ready),
    .sample     (sample),
    .sample_vld (sample_vld),
    .alarm_hot  (alarm_hot),
    .alarm_cold (alarm_cold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push n samples on consecutive cycles, then wait the two-cycle alarm latency.
  task automatic feed(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      sample = v; sample_vld = 1'b1;
      step();
    end
    sample_vld = 1'b0;
    step();
    step();
  endtask

  task automatic check_alarms(input logic exp_hot, input logic exp_cold, input string tag);
    checks++;
    if (alarm_hot !== exp_hot) begin
      errors++;
      $display("FAIL %s alarm_hot: got %b expected %b", tag, alarm_hot, exp_hot);
    end
    checks++;
    if (alarm_cold !== exp_cold) begin
      errors++;
      $display("FAIL %s alarm_cold: got %b expected %b", tag, alarm_cold, exp_cold);
    end
  endtask

  // Full command handshake: accept, EXEC, RESP, back to IDLE.
  task automatic run_cmd(input logic [2:0] c, input logic [7:0] d, input logic [1:0] exp, input string tag);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL %s ready_at_accept: got %b expected 1", tag, ready); end
    op = c; opnd = d;
    step();
    op = TMOD_NOP; opnd = 8'd0;
    checks++;
    if (ready !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL %s exec: got ready=%b valid=%b expected ready=0 valid=0", tag, ready, valid);
    end
    step();
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL %s resp_valid: got %b expected 1", tag, valid); end
    checks++;
    if (status !== exp) begin errors++; $display("FAIL %s status: got %b expected %b", tag, status, exp); end
    step();
    checks++;
    if (valid !== 1'b0 || ready !== 1'b1) begin
      errors++; $display("FAIL %s idle: got ready=%b valid=%b expected ready=1 valid=0", tag, ready, valid);
    end
    $display("cmd %s op=%0d opnd=%0d status=%b", tag, c, d, exp);
  endtask

  task automatic test_reset();
    reset = 1'b0; op = TMOD_NOP; opnd = 8'd0; sample = 8'd0; sample_vld = 1'b0;
    step(); step();
    checks++;
    if (status !== 2'b00 || valid !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got status=%b valid=%b ready=%b expected 00/0/0", status, valid, ready);
    end
    check_alarms(1'b0, 1'b0, "reset");
    reset = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b expected 0", ready); end
    step();
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ready_first_edge: got %b expected 1", ready); end
    run_cmd(TMOD_READ, 8'd0, TMOD_STATUS_OK, "read_after_reset");
    check_alarms(1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_hot();
    for (int i = 0; i < 4; i++) begin
      sample = 8'd90; sample_vld = 1'b1;
      step();
    end
    sample_vld = 1'b0;
    step();
    checks++;
    if (alarm_hot !== 1'b0) begin errors++; $display("FAIL hot_latency_early: got %b expected 0", alarm_hot); end
    step();
    checks++;
    if (alarm_hot !== 1'b1) begin errors++; $display("FAIL hot_latency: got %b expected 1", alarm_hot); end
    run_cmd(TMOD_READ, 8'd0, TMOD_STATUS_HOT, "read_hot");
    feed(8'd79, 4);      // averages 87,84,81,79: all above hi-hyst=78
    check_alarms(1'b1, 1'b0, "hot_hold_79");
    feed(8'd77, 4);      // first average 78 <= 78 releases to NORMAL
    check_alarms(1'b0, 1'b0, "hot_release_77");
    run_cmd(TMOD_READ, 8'd0, TMOD_STATUS_OK, "read_normal");
  endtask

  task automatic test_errors();
    run_cmd(TMOD_SET_LO,   8'd85, TMOD_STATUS_ERR, "set_lo_85");
    run_cmd(TMOD_SET_LO,   8'd80, TMOD_STATUS_ERR, "set_lo_eq_hi");
    run_cmd(TMOD_SET_HI,   8'd10, TMOD_STATUS_ERR, "set_hi_eq_lo");
    run_cmd(TMOD_SET_HI,   8'd5,  TMOD_STATUS_ERR, "set_hi_5");
    run_cmd(TMOD_SET_HYST, 8'd16, TMOD_STATUS_ERR, "set_hyst_16");
    run_cmd(3'd6,          8'd0,  TMOD_STATUS_ERR, "undef_6");
    run_cmd(3'd7,          8'd0,  TMOD_STATUS_ERR, "undef_7");
    run_cmd(TMOD_SET_HYST, 8'd2,  TMOD_STATUS_OK,  "set_hyst_2");
    feed(8'd50, 4);      // neither hi=5 nor lo=85 was written
    check_alarms(1'b0, 1'b0, "after_errors_50");
    run_cmd(TMOD_SET_HI,   8'd81, TMOD_STATUS_OK,  "set_hi_81");
    feed(8'd81, 4);      // 81 > 81 is false
    check_alarms(1'b0, 1'b0, "hi_81_boundary");
  endtask

  task automatic test_cold();
    feed(8'd5, 4);       // averages 62,43,24,5
    check_alarms(1'b0, 1'b1, "cold_5");
    run_cmd(TMOD_READ, 8'd0, TMOD_STATUS_COLD, "read_cold");
    feed(8'd4, 4);
    check_alarms(1'b0, 1'b1, "cold_4_lo10");
    run_cmd(TMOD_SET_LO, 8'd3, TMOD_STATUS_COLD, "set_lo_3");
    step(); step();
    check_alarms(1'b0, 1'b1, "cold_4_lo3");     // 4 < 3+2
    feed(8'd5, 4);       // averages 4,4,4,5; 5 >= 5 releases
    check_alarms(1'b0, 1'b0, "cold_release_5");
  endtask

  task automatic test_clr_avg();
    feed(8'd90, 4);
    check_alarms(1'b1, 1'b0, "pre_clear_hot");
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL clr_ready: got %b expected 1", ready); end
    op = TMOD_CLR_AVG; opnd = 8'd0;
    step();
    op = TMOD_NOP;
    sample = 8'd90; sample_vld = 1'b1;   // lands on the EXEC cycle and must be dropped
    step();
    sample_vld = 1'b0;
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL clr_valid: got %b expected 1", valid); end
    checks++;
    if (status !== TMOD_STATUS_OK) begin errors++; $display("FAIL clr_status: got %b expected 00", status); end
    check_alarms(1'b0, 1'b0, "clr_resp");
    step();
    $display("cmd clr_avg with sample on EXEC");
    feed(8'd90, 3);
    step(); step();
    check_alarms(1'b0, 1'b0, "clr_three_samples");
    feed(8'd90, 1);
    check_alarms(1'b1, 1'b0, "clr_fourth_sample");
    run_cmd(TMOD_READ, 8'd0, TMOD_STATUS_HOT, "read_hot_again");
  endtask

  task automatic test_reset_mid_cmd();
    op = TMOD_SET_HI; opnd = 8'd100;
    step();
    op = TMOD_NOP;
    reset = 1'b0;        // asserted during EXEC
    #1;
    checks++;
    if (status !== 2'b00 || valid !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got status=%b valid=%b ready=%b expected 00/0/0", status, valid, ready);
    end
    check_alarms(1'b0, 1'b0, "midreset");
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (valid !== 1'b0) begin errors++; $display("FAIL midreset_no_valid: got %b expected 0", valid); end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL midreset_ready_early: got %b expected 0", ready); end
    step();
    checks++;
    if (ready !== 1'b1 || valid !== 1'b0) begin
      errors++; $display("FAIL midreset_release: got ready=%b valid=%b expected 1/0", ready, valid);
    end
    feed(8'd81, 4);      // hi back to 80
    check_alarms(1'b1, 1'b0, "default_hi");
    feed(8'd79, 4);      // averages 80,80,79,79 stay above 78
    check_alarms(1'b1, 1'b0, "default_hyst_hold");
    feed(8'd78, 1);      // average 78 releases
    check_alarms(1'b0, 1'b0, "default_hyst_release");
    feed(8'd9, 4);       // lo back to 10
    check_alarms(1'b0, 1'b1, "default_lo");
  endtask

  initial begin
    test_reset();
    test_hot();
    test_errors();
    test_cold();
    test_clr_avg();
    test_reset_mid_cmd();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
